regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 74 +++++++
 rtl/regfile_mp.sv | 86 ++++++++
 tb/tb_regfile_mp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants and bus-slicing helpers for the multi-port register file.
// Both the storage array and the busy-bit scoreboard import this package.
package regfile_mp_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_AWIDTH = 5;
  localparam int DEF_NRD    = 2;
  localparam int DEF_NWR    = 2;

  localparam int RST_ZERO  = 0;
  localparam int RST_INDEX = 1;

  // Flattened buses carry port 0 in the LSBs; lane k starts at k*width.
  function automatic int laneLsb(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic int regCount(input int awidth);
    return 1 << awidth;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an issued but not yet written
// producer, keeps a running count and raises per-read-port hazard flags.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int NRD      = DEF_NRD,
  parameter int NWR      = DEF_NWR,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic [NWR-1:0]        r_wr_en,
  input  logic [NWR*AWIDTH-1:0] r_wr_addr,
  input  logic [NRD*AWIDTH-1:0] r_rd_addr,
  input  logic                  r_iss_en,
  input  logic [AWIDTH-1:0]     r_iss_addr,
  output logic [NRD-1:0]        r_rd_busy,
  output logic [AWIDTH:0]       r_busy_cnt
);

  localparam int DEPTH = regCount(AWIDTH);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_next;
  logic [AWIDTH:0]  w_setCnt;
  logic [AWIDTH:0]  w_clrCnt;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (r_iss_en && !(ZERO_REG == 1 && r_iss_addr == '0))
      w_set[r_iss_addr] = 1'b1;
    for (int p = 0; p < NWR; p++)
      if (r_wr_en[p])
        w_clr[r_wr_addr[laneLsb(p, AWIDTH) +: AWIDTH]] = 1'b1;
  end

  // A same-cycle issue beats a write, so set is applied after clear.
  assign w_next = (r_busy & ~w_clr) | w_set;

  // Count only real transitions so re-issues and stray clears leave it alone.
  always_comb begin
    w_setCnt = '0;
    w_clrCnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_set[i] && !r_busy[i])
        w_setCnt = w_setCnt + (AWIDTH+1)'(1);
      if (w_clr[i] && !w_set[i] && r_busy[i])
        w_clrCnt = w_clrCnt + (AWIDTH+1)'(1);
    end
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_next;
      r_busy_cnt <= r_busy_cnt + w_setCnt - w_clrCnt;
    end
  end

  always_comb begin
    r_rd_busy = '0;
    for (int k = 0; k < NRD; k++)
      r_rd_busy[k] = r_busy[r_rd_addr[laneLsb(k, AWIDTH) +: AWIDTH]] &&
                     !(BYPASS == 1 && w_clr[r_rd_addr[laneLsb(k, AWIDTH) +: AWIDTH]]);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional hard-wired zero register, write-to-read
// forwarding and an attached busy-bit scoreboard for hazard detection.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int NRD      = DEF_NRD,
  parameter int NWR      = DEF_NWR,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int RST_MODE = RST_INDEX
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic [NWR-1:0]        r_wr_en,
  input  logic [NWR*AWIDTH-1:0] r_wr_addr,
  input  logic [NWR*DWIDTH-1:0] r_wr_data,
  input  logic [NRD*AWIDTH-1:0] r_rd_addr,
  output logic [NRD*DWIDTH-1:0] r_rd_data,
  output logic [NRD-1:0]        r_rd_busy,
  input  logic                  r_iss_en,
  input  logic [AWIDTH-1:0]     r_iss_addr,
  output logic [AWIDTH:0]       r_busy_cnt
);

  localparam int DEPTH = regCount(AWIDTH);

  logic [DWIDTH-1:0] r_regs   [DEPTH];
  logic [AWIDTH-1:0] w_wrAddr [NWR];
  logic [DWIDTH-1:0] w_wrData [NWR];
  logic [AWIDTH-1:0] w_rdAddr [NRD];

  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      w_wrAddr[p] = r_wr_addr[laneLsb(p, AWIDTH) +: AWIDTH];
      w_wrData[p] = r_wr_data[laneLsb(p, DWIDTH) +: DWIDTH];
    end
    for (int k = 0; k < NRD; k++)
      w_rdAddr[k] = r_rd_addr[laneLsb(k, AWIDTH) +: AWIDTH];
  end

  // Higher-numbered write ports are applied last, so port 1 wins collisions.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= (RST_MODE == RST_INDEX) ? DWIDTH'(i) : '0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (r_wr_en[p] && !(ZERO_REG == 1 && w_wrAddr[p] == '0))
          r_regs[w_wrAddr[p]] <= w_wrData[p];
    end
  end

  always_comb begin
    r_rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      r_rd_data[laneLsb(k, DWIDTH) +: DWIDTH] = r_regs[w_rdAddr[k]];
      if (BYPASS == 1)
        for (int p = 0; p < NWR; p++)
          if (r_wr_en[p] && w_wrAddr[p] == w_rdAddr[k])
            r_rd_data[laneLsb(k, DWIDTH) +: DWIDTH] = w_wrData[p];
      if (ZERO_REG == 1 && w_rdAddr[k] == '0)
        r_rd_data[laneLsb(k, DWIDTH) +: DWIDTH] = '0;
    end
  end

  regfile_scoreboard #(
    .AWIDTH   (AWIDTH),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .r_clk      (r_clk),
    .r_rst      (r_rst),
    .r_wr_en    (r_wr_en),
    .r_wr_addr  (r_wr_addr),
    .r_rd_addr  (r_rd_addr),
    .r_iss_en   (r_iss_en),
    .r_iss_addr (r_iss_addr),
    .r_rd_busy  (r_rd_busy),
    .r_busy_cnt (r_busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: directed vector table, hand-written reset sequences and
// a randomized phase compared against an array-based register/scoreboard model.
module tb_regfile_mp;

  logic        r_clk;
  logic        r_rst;
  logic [1:0]  r_wr_en;
  logic [9:0]  r_wr_addr;
  logic [63:0] r_wr_data;
  logic [9:0]  r_rd_addr;
  logic [63:0] r_rd_data;
  logic [1:0]  r_rd_busy;
  logic        r_iss_en;
  logic [4:0]  r_iss_addr;
  logic [5:0]  r_busy_cnt;
  logic [63:0] nbRdData;
  logic [1:0]  nbRdBusy;
  logic [5:0]  nbBusyCnt;

  int checks;
  int failures;

  logic [31:0] modelRegs [32];
  bit          modelBusy [32];

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        ie;
    logic [4:0]  ia;
    logic [31:0] eRd0;
    logic [31:0] eRd1;
    logic [1:0]  eBusy;
    logic [5:0]  eCnt;
    logic [31:0] eNb0;
  } vec_t;

  vec_t vecs [13];

  regfile_mp #(.BYPASS(1)) dut (
    .r_clk      (r_clk),
    .r_rst      (r_rst),
    .r_wr_en    (r_wr_en),
    .r_wr_addr  (r_wr_addr),
    .r_wr_data  (r_wr_data),
    .r_rd_addr  (r_rd_addr),
    .r_rd_data  (r_rd_data),
    .r_rd_busy  (r_rd_busy),
    .r_iss_en   (r_iss_en),
    .r_iss_addr (r_iss_addr),
    .r_busy_cnt (r_busy_cnt)
  );

  regfile_mp #(.BYPASS(0)) dutNb (
    .r_clk      (r_clk),
    .r_rst      (r_rst),
    .r_wr_en    (r_wr_en),
    .r_wr_addr  (r_wr_addr),
    .r_wr_data  (r_wr_data),
    .r_rd_addr  (r_rd_addr),
    .r_rd_data  (nbRdData),
    .r_rd_busy  (nbRdBusy),
    .r_iss_en   (r_iss_en),
    .r_iss_addr (r_iss_addr),
    .r_busy_cnt (nbBusyCnt)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not terminate");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic ie, input logic [4:0] ia);
    @(negedge r_clk);
    r_wr_en    = we;
    r_wr_addr  = {wa1, wa0};
    r_wr_data  = {wd1, wd0};
    r_rd_addr  = {ra1, ra0};
    r_iss_en   = ie;
    r_iss_addr = ia;
    #1;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 32; i++) begin
      modelRegs[i] = 32'(i);
      modelBusy[i] = 1'b0;
    end
  endtask

  // Register file rules: port 1 lands after port 0, r0 is immutable,
  // writes free their destination and an issue re-marks it afterwards.
  task automatic modelUpdate();
    for (int p = 0; p < 2; p++) begin
      logic [4:0] a;
      a = r_wr_addr[p*5 +: 5];
      if (r_wr_en[p] && a != 5'd0) begin
        modelRegs[a] = r_wr_data[p*32 +: 32];
        modelBusy[a] = 1'b0;
      end
    end
    if (r_iss_en && r_iss_addr != 5'd0)
      modelBusy[r_iss_addr] = 1'b1;
  endtask

  task automatic runCycle();
    @(posedge r_clk);
    if (r_rst) modelUpdate();
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && r_wr_en[1] && r_wr_addr[9:5] == a) return r_wr_data[63:32];
    if (byp && r_wr_en[0] && r_wr_addr[4:0] == a) return r_wr_data[31:0];
    return modelRegs[a];
  endfunction

  function automatic logic expBusy(input logic [4:0] a, input bit byp);
    bit written;
    written = (r_wr_en[0] && r_wr_addr[4:0] == a) || (r_wr_en[1] && r_wr_addr[9:5] == a);
    return modelBusy[a] && !(byp && written);
  endfunction

  function automatic logic [31:0] expCnt();
    int n;
    n = 0;
    foreach (modelBusy[i]) n += int'(modelBusy[i]);
    return 32'(n);
  endfunction

  function automatic logic [4:0] randAddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{2'b00, 5'd0, 32'h0,    5'd0,  32'h0,    5'd5, 5'd31, 1'b0, 5'd0,  32'd5,    32'd31,   2'b00, 6'd0, 32'd5};
    vecs[1]  = '{2'b11, 5'd7, 32'hAAAA, 5'd7,  32'h5555, 5'd7, 5'd3,  1'b0, 5'd0,  32'h5555, 32'd3,    2'b00, 6'd0, 32'd7};
    vecs[2]  = '{2'b00, 5'd0, 32'h0,    5'd0,  32'h0,    5'd7, 5'd7,  1'b0, 5'd0,  32'h5555, 32'h5555, 2'b00, 6'd0, 32'h5555};
    vecs[3]  = '{2'b01, 5'd3, 32'h1234, 5'd0,  32'h0,    5'd3, 5'd3,  1'b0, 5'd0,  32'h1234, 32'h1234, 2'b00, 6'd0, 32'd3};
    vecs[4]  = '{2'b01, 5'd0, 32'hFFFF, 5'd0,  32'h0,    5'd0, 5'd3,  1'b1, 5'd0,  32'd0,    32'h1234, 2'b00, 6'd0, 32'd0};
    vecs[5]  = '{2'b00, 5'd0, 32'h0,    5'd0,  32'h0,    5'd0, 5'd9,  1'b0, 5'd0,  32'd0,    32'd9,    2'b00, 6'd0, 32'd0};
    vecs[6]  = '{2'b00, 5'd0, 32'h0,    5'd0,  32'h0,    5'd9, 5'd10, 1'b1, 5'd9,  32'd9,    32'd10,   2'b00, 6'd0, 32'd9};
    vecs[7]  = '{2'b00, 5'd0, 32'h0,    5'd0,  32'h0,    5'd9, 5'd10, 1'b1, 5'd10, 32'd9,    32'd10,   2'b01, 6'd1, 32'd9};
    vecs[8]  = '{2'b00, 5'd0, 32'h0,    5'd0,  32'h0,    5'd9, 5'd10, 1'b0, 5'd0,  32'd9,    32'd10,   2'b11, 6'd2, 32'd9};
    vecs[9]  = '{2'b01, 5'd9, 32'h99,   5'd0,  32'h0,    5'd9, 5'd10, 1'b0, 5'd0,  32'h99,   32'd10,   2'b10, 6'd2, 32'd9};
    vecs[10] = '{2'b00, 5'd0, 32'h0,    5'd0,  32'h0,    5'd9, 5'd10, 1'b0, 5'd0,  32'h99,   32'd10,   2'b10, 6'd1, 32'h99};
    vecs[11] = '{2'b10, 5'd0, 32'h0,    5'd10, 32'h1010, 5'd9, 5'd10, 1'b1, 5'd10, 32'h99,   32'h1010, 2'b00, 6'd1, 32'h99};
    vecs[12] = '{2'b00, 5'd0, 32'h0,    5'd0,  32'h0,    5'd9, 5'd10, 1'b0, 5'd0,  32'h99,   32'h1010, 2'b10, 6'd1, 32'h99};

    r_rst      = 1'b0;
    r_wr_en    = '0;
    r_wr_addr  = '0;
    r_wr_data  = '0;
    r_rd_addr  = '0;
    r_iss_en   = 1'b0;
    r_iss_addr = '0;
    resetModel();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b0, 5'd0);
    checkOutput("inReset_cnt", 32'(r_busy_cnt), 32'd0);
    checkOutput("inReset_rd5", r_rd_data[31:0], 32'd5);
    repeat (2) @(posedge r_clk);
    @(negedge r_clk);
    r_rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
                    vecs[i].ra0, vecs[i].ra1, vecs[i].ie, vecs[i].ia);
      checkOutput($sformatf("vec%0d_rd0", i), r_rd_data[31:0], vecs[i].eRd0);
      checkOutput($sformatf("vec%0d_rd1", i), r_rd_data[63:32], vecs[i].eRd1);
      checkOutput($sformatf("vec%0d_busy", i), 32'(r_rd_busy), 32'(vecs[i].eBusy));
      checkOutput($sformatf("vec%0d_cnt", i), 32'(r_busy_cnt), 32'(vecs[i].eCnt));
      checkOutput($sformatf("vec%0d_nbRd0", i), nbRdData[31:0], vecs[i].eNb0);
      runCycle();
    end

    // Build three busy registers, then pull reset between clock edges.
    applyStimulus(2'b01, 5'd10, 32'h0A0A, 5'd0, 32'h0, 5'd20, 5'd21, 1'b1, 5'd20);
    runCycle();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd20, 5'd21, 1'b1, 5'd21);
    runCycle();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd20, 5'd21, 1'b1, 5'd22);
    runCycle();
    applyStimulus(2'b01, 5'd20, 32'hBEEF, 5'd0, 32'h0, 5'd20, 5'd21, 1'b0, 5'd0);
    checkOutput("midop_cntBefore", 32'(r_busy_cnt), 32'd3);
    checkOutput("midop_busyBefore", 32'(r_rd_busy), 32'b10);
    #2;
    r_rst = 1'b0;
    resetModel();
    #1;
    checkOutput("midop_cntAfter", 32'(r_busy_cnt), 32'd0);
    checkOutput("midop_busyAfter", 32'(r_rd_busy), 32'd0);
    checkOutput("midop_rd21", r_rd_data[63:32], 32'd21);

    // Writes and issues while reset is held must not stick.
    applyStimulus(2'b01, 5'd5, 32'hDEAD, 5'd0, 32'h0, 5'd5, 5'd6, 1'b1, 5'd6);
    runCycle();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd0);
    checkOutput("heldRst_rd5", r_rd_data[31:0], 32'd5);
    checkOutput("heldRst_busy6", 32'(r_rd_busy), 32'd0);
    checkOutput("heldRst_cnt", 32'(r_busy_cnt), 32'd0);
    #2;
    r_rst = 1'b1;

    for (int c = 0; c < 400; c++) begin
      logic [4:0] ra0;
      logic [4:0] ra1;
      ra0 = randAddr();
      ra1 = randAddr();
      applyStimulus(2'($urandom_range(0, 3)), randAddr(), $urandom(), randAddr(), $urandom(),
                    ra0, ra1, 1'($urandom_range(0, 1)), randAddr());
      checkOutput($sformatf("rnd%0d_rd0", c), r_rd_data[31:0], expRead(ra0, 1'b1));
      checkOutput($sformatf("rnd%0d_rd1", c), r_rd_data[63:32], expRead(ra1, 1'b1));
      checkOutput($sformatf("rnd%0d_busy", c), 32'(r_rd_busy), 32'({expBusy(ra1, 1'b1), expBusy(ra0, 1'b1)}));
      checkOutput($sformatf("rnd%0d_cnt", c), 32'(r_busy_cnt), expCnt());
      checkOutput($sformatf("rnd%0d_nbRd0", c), nbRdData[31:0], expRead(ra0, 1'b0));
      checkOutput($sformatf("rnd%0d_nbRd1", c), nbRdData[63:32], expRead(ra1, 1'b0));
      checkOutput($sformatf("rnd%0d_nbBusy", c), 32'(nbRdBusy), 32'({expBusy(ra1, 1'b0), expBusy(ra0, 1'b0)}));
      checkOutput($sformatf("rnd%0d_nbCnt", c), 32'(nbBusyCnt), expCnt());
      runCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
